// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sequencer state encoding, instruction field positions and flag indices.
package cpu_pkg;
   typedef enum logic [2:0] {S_PAUSE, S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT} state_t;
   localparam int OPCODE_MSB = 14;
   localparam int OPCODE_LSB = 8;
   localparam logic [6:0] HALT_OPCODE = 7'b1111111;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;
endpackage

// File: rtl/cpu_sequencer_pc_unit.sv
// seq_pc_unit: program counter with hold / increment-wrap / load-target selection.
module seq_pc_unit #(
   parameter int PC_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_update,
   input  logic                i_load,
   input  logic [PC_WIDTH-1:0] i_target,
   output logic [PC_WIDTH-1:0] o_pc
);
   logic [PC_WIDTH-1:0] r_pc;
   always_ff @(posedge clk)
      r_pc <= rst ? '0 : !i_update ? r_pc : i_load ? i_target : r_pc + PC_WIDTH'(1);
   assign o_pc = r_pc;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: 4-cycle fetch/decode/exec/update sequencer with run, single-step and sticky halt.
module cpu_sequencer import cpu_pkg::*; #(
   parameter int         PC_WIDTH    = 8,
   parameter int         INSTR_WIDTH = 15,
   parameter logic [6:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE,
   parameter int         CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic                   step,
   input  logic [INSTR_WIDTH-1:0] instr_data,
   input  logic                   cu_l_pc,
   input  logic                   cu_d_w,
   input  logic                   cu_l_a,
   input  logic                   cu_l_b,
   input  logic [3:0]             alu_flags,
   output logic [PC_WIDTH-1:0]    pc,
   output logic [INSTR_WIDTH-1:0] ir,
   output logic [6:0]             opcode,
   output logic [3:0]             status_flags,
   output logic                   l_a_en,
   output logic                   l_b_en,
   output logic                   d_w_en,
   output logic                   busy,
   output logic                   halted,
   output logic [CNT_WIDTH-1:0]   instr_count
);
   state_t                 r_state, w_next;
   logic [INSTR_WIDTH-1:0] r_ir;
   logic [3:0]             r_flags;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic                   r_take_jump;
   logic                   w_exec;
   assign w_exec = r_state == S_EXEC;
   always_ff @(posedge clk)
      r_state <= reset ? S_PAUSE : w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_PAUSE:  w_next = (run | step) ? S_FETCH : S_PAUSE;
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: w_next = (instr_data[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) ? S_HALT : S_EXEC;
         S_EXEC:   w_next = S_UPDATE;
         S_UPDATE: w_next = run ? S_FETCH : S_PAUSE;
         default:  w_next = S_HALT;
      endcase
   end
   // Flags only move at the end of EXEC, so control_unit sees them stable for the whole instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ir        <= '0;
         r_flags     <= '0;
         r_cnt       <= '0;
         r_take_jump <= 1'b0;
      end else begin
         if (r_state == S_DECODE) r_ir <= instr_data;
         if (w_exec) r_take_jump <= cu_l_pc;
         if (w_exec && !cu_l_pc && (cu_l_a | cu_l_b | cu_d_w)) r_flags <= alu_flags;
         if (r_state == S_UPDATE && r_cnt != '1) r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end
   seq_pc_unit #(.PC_WIDTH(PC_WIDTH)) u_pc (
      .clk      (clk),
      .rst      (reset),
      .i_update (r_state == S_UPDATE),
      .i_load   (r_take_jump),
      .i_target (r_ir[PC_WIDTH-1:0]),
      .o_pc     (pc)
   );
   assign ir           = r_ir;
   assign opcode       = r_ir[OPCODE_MSB:OPCODE_LSB];
   assign status_flags = r_flags;
   assign l_a_en       = w_exec & cu_l_a;
   assign l_b_en       = w_exec & cu_l_b;
   assign d_w_en       = w_exec & cu_d_w;
   assign busy         = r_state inside {S_FETCH, S_DECODE, S_EXEC, S_UPDATE};
   assign halted       = r_state == S_HALT;
   assign instr_count  = r_cnt;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: instruction-level reference model checked every cycle, plus directed literal checks.
module tb_cpu_sequencer;
   logic        clk = 1'b0, reset = 1'b1, run = 1'b0, step = 1'b0;
   logic [14:0] instr_data;
   logic        cu_l_pc, cu_d_w, cu_l_a, cu_l_b;
   logic [3:0]  alu_flags = 4'b0000;
   logic [7:0]  pc;
   logic [14:0] ir;
   logic [6:0]  opcode;
   logic [3:0]  status_flags;
   logic        l_a_en, l_b_en, d_w_en, busy, halted;
   logic [15:0] instr_count;
   logic [14:0] rom [256];
   int          n_tests = 0, n_fail = 0, cyc = 0, rel0 = 0, dw_n = 0;
   int          la_q[$];
   int          m_k = -1;
   bit          m_valid = 0, m_halt = 0, m_jump = 0;
   logic [7:0]  m_pc;
   logic [14:0] m_ir;
   logic [3:0]  m_flags;
   logic [15:0] m_cnt;

   cpu_sequencer dut (
      .clk(clk), .reset(reset), .run(run), .step(step), .instr_data(instr_data),
      .cu_l_pc(cu_l_pc), .cu_d_w(cu_d_w), .cu_l_a(cu_l_a), .cu_l_b(cu_l_b), .alu_flags(alu_flags),
      .pc(pc), .ir(ir), .opcode(opcode), .status_flags(status_flags),
      .l_a_en(l_a_en), .l_b_en(l_b_en), .d_w_en(d_w_en), .busy(busy), .halted(halted),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) begin
      instr_data <= rom[pc];
      cyc        <= cyc + 1;
   end

   // Toy control unit: 01 MOV / 02 ADD load A, 03 JMP, 04 NOT writes memory, 05 loads B.
   assign cu_l_a  = opcode == 7'h01 || opcode == 7'h02;
   assign cu_l_pc = opcode == 7'h03;
   assign cu_d_w  = opcode == 7'h04;
   assign cu_l_b  = opcode == 7'h05;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // m_k = position inside the current 4-cycle instruction, -1 when idle or halted.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("pc", pc, m_pc);
         chk("ir", ir, m_ir);
         chk("opcode", opcode, m_ir[14:8]);
         chk("status_flags", status_flags, m_flags);
         chk("instr_count", instr_count, m_cnt);
         chk("busy", busy, m_k >= 0);
         chk("halted", halted, m_halt);
         chk("l_a_en", l_a_en, m_k == 2 && cu_l_a);
         chk("l_b_en", l_b_en, m_k == 2 && cu_l_b);
         chk("d_w_en", d_w_en, m_k == 2 && cu_d_w);
      end
      if (l_a_en === 1'b1) la_q.push_back(cyc - rel0);
      if (d_w_en === 1'b1) dw_n++;
      if (reset) begin
         m_valid = 1; m_k = -1; m_halt = 0; m_jump = 0;
         m_pc = 0; m_ir = 0; m_flags = 0; m_cnt = 0;
      end else if (m_valid && !m_halt) begin
         if (m_k == -1) begin
            if (run || step) m_k = 0;
         end else if (m_k == 0) m_k = 1;
         else if (m_k == 1) begin
            m_ir = instr_data;
            if (instr_data[14:8] == 7'h7F) begin m_halt = 1; m_k = -1; end
            else m_k = 2;
         end else if (m_k == 2) begin
            m_jump = cu_l_pc;
            if (!cu_l_pc && (cu_l_a || cu_l_b || cu_d_w)) m_flags = alu_flags;
            m_k = 3;
         end else begin
            m_pc = m_jump ? m_ir[7:0] : m_pc + 8'd1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_k = run ? 0 : -1;
         end
      end
   end

   initial begin
      int base_dw, base_la, a0, a1;
      for (int i = 0; i < 256; i++) rom[i] = 15'h0000;
      rom[0] = {7'h01, 8'h00};
      rom[1] = {7'h02, 8'h00};
      tick(3);
      chk("reset pc", pc, 8'h00);
      chk("reset busy", busy, 1'b0);
      chk("reset count", instr_count, 16'h0);
      chk("reset flags", status_flags, 4'h0);
      // Continuous run: MOV then ADD, run dropped mid-way through the second one.
      reset = 0; run = 1; rel0 = cyc;
      tick(5);
      chk("t1 pc after MOV", pc, 8'h01);
      run = 0;
      tick(5);
      a0 = la_q.size() > 0 ? la_q[0] : -1;
      a1 = la_q.size() > 1 ? la_q[1] : -1;
      chk("t1 l_a pulses", la_q.size(), 2);
      chk("t1 first l_a cycle", a0, 3);
      chk("t1 second l_a cycle", a1, 7);
      chk("t1 pc", pc, 8'h02);
      chk("t1 count", instr_count, 16'd2);
      chk("t1 paused", busy, 1'b0);
      // Single step, with a stray step pulse during EXEC.
      reset = 1; tick(1); reset = 0;
      tick(20);
      chk("t2 idle pc", pc, 8'h00);
      chk("t2 idle busy", busy, 1'b0);
      step = 1; tick(1); step = 0;
      tick(2);
      chk("t2 in EXEC l_a", l_a_en, 1'b1);
      step = 1; tick(1); step = 0;
      tick(6);
      chk("t2 count", instr_count, 16'd1);
      chk("t2 pc", pc, 8'h01);
      chk("t2 paused", busy, 1'b0);
      // Jump, flag update, memory write, then halt.
      rom[0] = {7'h03, 8'h2A};
      rom[8'h2A] = {7'h02, 8'h00};
      rom[8'h2B] = {7'h04, 8'h00};
      rom[8'h2C] = {7'h7F, 8'h00};
      alu_flags = 4'b0110;
      reset = 1; tick(1); reset = 0; run = 1;
      tick(5);
      chk("t3 jump pc", pc, 8'h2A);
      chk("t3 flags untouched", status_flags, 4'b0000);
      alu_flags = 4'b1000;
      tick(4);
      chk("t4 ADD flags", status_flags, 4'b1000);
      base_dw = dw_n; base_la = la_q.size();
      tick(6);
      chk("t4 d_w pulses", dw_n - base_dw, 1);
      chk("t4 l_a during NOT", la_q.size() - base_la, 0);
      chk("t5 halted", halted, 1'b1);
      chk("t5 pc", pc, 8'h2C);
      for (int i = 0; i < 10; i++) begin
         run = ~run; step = ~step; tick(1);
      end
      chk("t5 pc frozen", pc, 8'h2C);
      chk("t5 still halted", halted, 1'b1);
      chk("t5 count", instr_count, 16'd3);
      chk("t5 ir", ir, 15'h7F00);
      reset = 1; tick(1); reset = 0; run = 0; step = 0;
      chk("t5 reset pc", pc, 8'h00);
      chk("t5 reset halted", halted, 1'b0);
      chk("t5 reset busy", busy, 1'b0);
      // PC wrap at 0xFF, then reset in the middle of EXEC.
      rom[0] = {7'h03, 8'hFF};
      reset = 1; tick(1); reset = 0; run = 1;
      tick(5);
      chk("t6 pc at FF", pc, 8'hFF);
      tick(4);
      chk("t6 pc wrapped", pc, 8'h00);
      chk("t6 count", instr_count, 16'd2);
      rom[0] = {7'h04, 8'h00};
      tick(2);
      chk("t6 d_w in EXEC", d_w_en, 1'b1);
      reset = 1; tick(1);
      chk("t6 d_w after reset", d_w_en, 1'b0);
      chk("t6 pc after reset", pc, 8'h00);
      chk("t6 count after reset", instr_count, 16'd0);
      chk("t6 busy after reset", busy, 1'b0);
      reset = 0; run = 0;
      tick(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle instruction sequencer for the 15-bit ISA.
- Owns the PC, the instruction register (IR) and the registered {Z,N,C,V} status register.
- The IR opcode field and status register drive control_unit combinationally; this block gates control_unit's load/write strobes into one EXEC cycle per instruction and computes the next PC.
- Supports continuous run, single-step (debug button) and a sticky HALT.

Parameters:
- PC_WIDTH, 8, instruction-memory address width; jump target = IR[PC_WIDTH-1:0].
- INSTR_WIDTH, 15, instruction word width; opcode = IR[14:8].
- HALT_OPCODE, 7'b1111111, opcode that stops the sequencer.
- CNT_WIDTH, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level: 1 = continuous execution, 0 = single-step mode.
- step  in  1  one-cycle pulse (debounced upstream); starts one instruction when in PAUSE.
- instr_data  in  INSTR_WIDTH  synchronous ROM output; valid the cycle after pc is presented.
- cu_l_pc, cu_d_w, cu_l_a, cu_l_b  in  1 each  raw control_unit strobes.
- alu_flags  in  4  {Z,N,C,V} from the ALU, combinational.
- pc  out  PC_WIDTH  instruction-memory address.
- ir  out  INSTR_WIDTH  latched instruction.
- opcode  out  7  ir[14:8], to control_unit.
- status_flags  out  4  registered {Z,N,C,V}, to control_unit.
- l_a_en, l_b_en, d_w_en  out  1 each  gated strobes to reg A, reg B and data memory.
- busy  out  1  high in FETCH, DECODE, EXEC and UPDATE.
- halted  out  1  high in HALT.
- instr_count  out  CNT_WIDTH  retired instructions.

Behaviour:
- Reset (synchronous; wins over everything, including mid-instruction):
  - state = PAUSE.
  - pc, ir, status_flags, instr_count = 0.
  - All enables low from the cycle after the reset edge.
- States: PAUSE, FETCH, DECODE, EXEC, UPDATE, HALT. Every instruction takes exactly 4 cycles: FETCH -> DECODE -> EXEC -> UPDATE.
- PAUSE:
  - run = 1 -> FETCH.
  - run = 0 and step = 1 -> FETCH.
  - Otherwise stay.
- FETCH: pc held stable; ROM latency cycle.
- DECODE: ir <= instr_data.
  - ir[14:8] == HALT_OPCODE -> HALT.
  - Otherwise -> EXEC.
- EXEC (the only cycle the enables can be high):
  - l_a_en = cu_l_a, l_b_en = cu_l_b, d_w_en = cu_d_w.
  - If cu_l_pc = 0 and any of cu_l_a/cu_l_b/cu_d_w = 1: status_flags <= alu_flags at the end of EXEC.
  - Jumps (cu_l_pc = 1) never update flags.
  - The jump decision cu_l_pc is sampled into an internal take_jump register.
- UPDATE:
  - take_jump -> pc <= ir[PC_WIDTH-1:0].
  - Otherwise pc <= pc + 1, wrapping from all-ones to 0 with no halt.
  - instr_count increments and saturates at all-ones.
  - Next state: run = 1 -> FETCH; run = 0 -> PAUSE.
- HALT:
  - Sticky; only reset exits.
  - pc, ir, status_flags and instr_count frozen; enables low; run and step ignored.
  - A HALT instruction does not increment instr_count.
- step pulses outside PAUSE are ignored and not queued.
- Toggling run mid-instruction takes effect only at the UPDATE decision.
- status_flags is stable throughout DECODE/EXEC, so control_unit's conditional-jump evaluation is glitch-free in EXEC.
- Enables are combinational decodes of (state == EXEC) & cu_*. No enable may be high in any other state.

Decomposition:
- Shared package cpu_pkg:
  - state enum.
  - OPCODE_MSB/LSB field constants.
  - HALT_OPCODE.
  - Flag bit indices FLAG_Z = 3, FLAG_N = 2, FLAG_C = 1, FLAG_V = 0.
- One natural sub-module, seq_pc_unit: the PC register plus next-PC mux (hold / increment-wrap / load target), driven by the FSM.

Test Plan:
1. run = 1, ROM[0] = MOV, ROM[1] = ADD, cu_l_a = 1 -> l_a_en pulses exactly in cycles 3 and 7 after reset release; pc = 1 then 2; instr_count = 2.
2. run = 0, no step for 20 cycles -> pc = 0, busy = 0. Then one step pulse -> exactly one instruction, instr_count = 1, back in PAUSE; a step pulse during EXEC is ignored.
3. EXEC with cu_l_pc = 1, ir[7:0] = 8'h2A, alu_flags = 4'b0110 -> pc = 8'h2A after UPDATE; status_flags unchanged (0000).
4. ADD with alu_flags = 4'b1000 -> status_flags = 1000 after EXEC. Then NOT (cu_d_w = 1) -> d_w_en high one cycle only; l_a_en stays low.
5. ROM[pc] opcode = 7'h7F -> halted = 1, all enables low, pc frozen across run/step toggles for 10 cycles; reset -> PAUSE, pc = 0.
6. pc = 8'hFF, non-jump -> pc = 8'h00 after UPDATE. Reset asserted during EXEC with cu_d_w = 1 -> d_w_en low the next cycle, pc = 0, instr_count = 0, state PAUSE.
